// File: rtl/machine_timer_if.sv
// Request/response bus between the load/store unit's uncached I/O path and
// the machine timer.
//
// Handshake: a request transfers on any clk edge where reqValid && reqReady.
// Writes complete at that edge with no response. An accepted read yields
// rspValid for exactly one cycle after the accepting edge, with rspData
// holding the word sampled at that edge. reqReady drops for the one cycle
// following an accepted read, so only one read is ever outstanding.
interface machine_timer_if;
  logic        reqValid;
  logic        reqWE;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic        reqReady;
  logic        rspValid;
  logic [31:0] rspData;

  modport master (
    output reqValid, reqWE, reqAddr, reqWData,
    input  reqReady, rspValid, rspData
  );

  modport slave (
    input  reqValid, reqWE, reqAddr, reqWData,
    output reqReady, rspValid, rspData
  );
endinterface

// File: rtl/machine_timer.sv
// RISC-V machine timer: prescaled 64-bit mtime, 64-bit mtimecmp and a
// registered level timer-interrupt request for the CSR unit (mip.MTIP).
module machine_timer #(
  parameter int unsigned PRESCALE   = 1,
  parameter logic [31:0] TIMER_BASE = 32'h4000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  machine_timer_if.slave        bus,
  input  logic                  freeze,
  output logic                  reqTimerInterrupt,
  output logic [63:0]           mtimeOut
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        irq_q;

  logic        hit;
  logic [1:0]  word;
  logic        acc_wr;
  logic        acc_rd;
  logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi;
  logic        tick;
  logic [31:0] rd_data;

  assign hit  = (bus.reqAddr[31:4] == TIMER_BASE[31:4]);
  assign word = bus.reqAddr[3:2];

  assign acc_wr = bus.reqValid && ready_q && bus.reqWE && hit;
  // Reads outside the block are still accepted and answered with zero.
  assign acc_rd = bus.reqValid && ready_q && !bus.reqWE;

  assign wr_mtime_lo = acc_wr && (word == 2'd0);
  assign wr_mtime_hi = acc_wr && (word == 2'd1);
  assign wr_cmp_lo   = acc_wr && (word == 2'd2);
  assign wr_cmp_hi   = acc_wr && (word == 2'd3);

  assign tick = !freeze && (presc_q == PRESC_MAX);

  // Read mux: register values as they stand before this edge's updates.
  always_comb begin
    rd_data = 32'd0;
    if (hit) begin
      case (word)
        2'd0:    rd_data = mtime_q[31:0];
        2'd1:    rd_data = mtime_q[63:32];
        2'd2:    rd_data = cmp_q[31:0];
        default: rd_data = cmp_q[63:32];
      endcase
    end
  end

  // Next prescaler/mtime/mtimecmp; a write to either mtime half swallows
  // that cycle's tick entirely and restarts the prescaler.
  always_comb begin
    presc_d = presc_q;
    mtime_d = mtime_q;
    cmp_d   = cmp_q;
    if (wr_mtime_lo || wr_mtime_hi) begin
      presc_d = 16'd0;
      if (wr_mtime_lo) mtime_d[31:0]  = bus.reqWData;
      if (wr_mtime_hi) mtime_d[63:32] = bus.reqWData;
    end else if (!freeze) begin
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
      if (tick) mtime_d = mtime_q + 64'd1;
    end
    if (wr_cmp_lo) cmp_d[31:0]  = bus.reqWData;
    if (wr_cmp_hi) cmp_d[63:32] = bus.reqWData;
  end

  // Timer state; interrupt compares the post-update values so it has no lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= 16'd0;
      mtime_q <= 64'd0;
      cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      irq_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      irq_q   <= (mtime_d >= cmp_d);
    end
  end

  // Bus side: ready drops for one cycle after each accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else begin
      ready_q     <= !acc_rd;
      rsp_valid_q <= acc_rd;
      if (acc_rd) rsp_data_q <= rd_data;
    end
  end

  assign bus.reqReady   = ready_q;
  assign bus.rspValid   = rsp_valid_q;
  assign bus.rspData    = rsp_data_q;
  assign reqTimerInterrupt = irq_q;
  assign mtimeOut       = mtime_q;

endmodule
